// File: rtl/divu_sequencer.sv
// divu_sequencer: multi-cycle unsigned divide controller for the EX stage.
// Runs a restoring shift-subtract divide, one quotient bit per cycle, holds the
// pipeline stall line while busy and presents the results for a single cycle.
`timescale 1ns/1ps

module divu_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter value seen in the final RUN cycle.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic             trial_neg;

    // One restoring step: shift {R,Q} left and trial-subtract the divisor.
    // R < divisor always holds, so bit WIDTH of trial is set exactly when
    // the subtraction borrowed.
    always_comb begin
        r_shift   = {r_q, q_q[WIDTH-1]};
        trial     = r_shift - {1'b0, dvsr_q};
        trial_neg = trial[WIDTH];
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    if (divisor != '0) begin
                        dvsr_d  = divisor;
                        q_d     = dividend;
                        r_d     = '0;
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        // Divide by zero: skip RUN, report all-ones / dividend.
                        q_d     = '1;
                        r_d     = dividend;
                        state_d = StDone;
                    end
                end
            end

            StRun: begin
                if (trial_neg) begin
                    r_d = r_shift[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end else begin
                    r_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Flush aborts from any state; register contents are left as-is.
        if (flush) begin
            state_d = StIdle;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            q_q     <= '0;
            r_q     <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs: stall follows start combinationally in IDLE so the requesting
    // instruction freezes in the cycle it arrives; results gated by done.
    always_comb begin
        busy      = (state_q == StRun);
        stall     = ((state_q == StIdle) && start) || (state_q == StRun);
        done      = (state_q == StDone) && !flush;
        quotient  = done ? q_q : '0;
        remainder = done ? r_q : '0;
    end

endmodule

// File: doc/divu_sequencer.md
# divu_sequencer

Multi-cycle controller for the unsigned divide (ALU_DIVU) in the EX stage of the 5-stage MIPS pipeline.
- Accepts a divide request, runs a restoring shift-subtract divide one quotient bit per cycle, and holds the pipeline stall line for the duration.
- Presents quotient and remainder for exactly one cycle when finished, so the EX/MEM register captures them as the divide instruction advances.
- Honours pipeline flush and asynchronous reset at any point.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  divide request; sampled only in IDLE
- dividend  input  WIDTH  rs operand; latched when start is accepted
- divisor  input  WIDTH  rt operand; latched when start is accepted
- flush  input  1  abort any in-flight divide
- busy  output  1  high in RUN
- stall  output  1  freezes IF/ID/EX: (IDLE & start) | RUN
- done  output  1  single-cycle pulse; results valid
- quotient  output  WIDTH  valid only while done=1, else 0
- remainder  output  WIDTH  valid only while done=1, else 0

## Operation
- States: IDLE, RUN, DONE; 2-bit state register.
- IDLE, start=1, flush=0, divisor!=0:
  - Latch divisor; Q register = dividend; R register = 0; counter = 0.
  - Next state: RUN.
- IDLE, start=1, flush=0, divisor==0:
  - Q = all ones; R = dividend.
  - Next state: DONE; no RUN cycles.
- RUN, each cycle:
  - Form {R,Q} shifted left 1 (WIDTH+1-bit trial path).
  - trial = R_shifted − divisor, computed at WIDTH+1 bits.
  - trial ≥ 0: R = trial, Q LSB = 1. Otherwise R = R_shifted, Q LSB = 0.
  - counter increments. When counter == WIDTH−1 this cycle, next state is DONE.
- DONE: done=1, quotient=Q, remainder=R. Next state is IDLE unconditionally.
- start is ignored in RUN and DONE. A new request is accepted on the first IDLE cycle after DONE.
- flush=1 in any state:
  - Next state is IDLE; no done pulse.
  - Q/R/counter contents are don't-care but outputs stay 0.
  - If start and flush are both high in IDLE, flush wins and the request is dropped.
- rst_n low, asynchronously and at any time (including mid-RUN):
  - state = IDLE; Q, R, counter cleared.
  - Outputs: busy=0, stall=0, done=0, quotient=0, remainder=0.
  - No pending request survives reset.
- All arithmetic is unsigned. No overflow is possible.

## Timing
- Reset values: every output 0; state IDLE.
- stall is combinational from start in IDLE, so the requesting instruction is frozen in EX in the same cycle it arrives.
- Let cycle T be the IDLE cycle in which start is accepted:
  - RUN occupies T+1 … T+WIDTH (32 cycles at default).
  - DONE is T+WIDTH+1; done=1 and stall=0 there.
  - The pipeline advances at the end of cycle T+WIDTH+1, capturing the results.
  - Total stall cycles: WIDTH+1 (T through T+WIDTH).
- Divide by zero: DONE at T+1; 1 stall cycle.
- busy=1 exactly in RUN cycles; done never coincides with busy or stall.
- flush asserted in cycle F: state is IDLE at F+1; stall and busy drop at F+1 (stall still follows start in F+1).

## Test plan
- Basic divide: start with dividend=100, divisor=7 at cycle T. Required:
  - stall high T…T+32.
  - done=1 only at T+33, with quotient=14, remainder=2.
  - All outputs 0 at T+34.
- Extreme values:
  - 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
  - 5/0xFFFFFFFF → quotient=0, remainder=5.
  - Both complete in 33 cycles.
- Divide by zero: dividend=0x1234, divisor=0 → done at T+1 with quotient=0xFFFFFFFF, remainder=0x1234; stall high only in T.
- Flush mid-run: flush at T+10 → state IDLE at T+11, busy=stall=0, no done pulse ever. A new start at T+12 with 9/3 gives done at T+45 with quotient=3, remainder=0.
- Reset mid-run: drop rst_n asynchronously at T+5 (between edges) → all outputs 0 immediately. After release, start 20/6 → quotient=3, remainder=2 after 33 cycles.
- Start held high continuously across two divides (40/4, then 7/2 presented from the DONE cycle onward):
  - Start is ignored in RUN and DONE.
  - Second divide is accepted at T+34 and completes at T+67 with quotient=3, remainder=1.
